// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared state codes and default timing constants for the snake display path
package frame_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_UPDATE = 3'd2,
        S_SNAP   = 3'd3,
        S_SEND   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    localparam int FRAME_CYC_DEF = 1_666_666;
    localparam int GAP_CYC_DEF   = 15_000;

endpackage

// File: rtl/frame_sched_if.sv
// frame_sched_if: handshakes between the frame scheduler, snake engine and ws2812 serializer
interface frame_sched_if;

    logic game_req;
    logic game_ack;
    logic snap_en;
    logic tx_start;
    logic tx_done;
    logic line_hold;

    modport master (
        output game_req, snap_en, tx_start, line_hold,
        input  game_ack, tx_done
    );

    modport slave (
        input  game_req, snap_en, tx_start, line_hold,
        output game_ack, tx_done
    );

endinterface

// File: rtl/frame_sched_tick.sv
// frame_tick_gen: free-running divider producing a one-cycle tick every CYC cycles
module frame_tick_gen
    import frame_sched_pkg::*;
#(
    parameter int CYC = FRAME_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(CYC);

    logic [CW-1:0] cnt;

    // count 0..CYC-1 and flag the wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt == CW'(CYC - 1) ? '0 : cnt + 1'b1;
            tick <= cnt == CW'(CYC - 1);
        end
    end

endmodule

// File: rtl/frame_sched.sv
// frame_sched: sequences game step, snapshot, ws2812 transmit and latch gap once per frame tick
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int FRAME_CYC = FRAME_CYC_DEF,
    parameter int GAME_DIV  = 8,
    parameter int GAP_CYC   = GAP_CYC_DEF,
    parameter int ACK_TO    = 4096
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          run,
    frame_sched_if.master bus,
    output logic [15:0]   frame_cnt,
    output logic [2:0]    state,
    output logic          overrun,
    output logic          ack_err
);

    localparam int TW = $clog2(ACK_TO + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    state_t        st, st_n;
    logic          tick, ack_ok, to_done, gap_done;
    logic [7:0]    div;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;

    frame_tick_gen #(.CYC(FRAME_CYC)) u_tick (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .tick (tick)
    );

    assign state = st;

    // next state; ack is only honoured after the first UPDATE cycle
    always_comb begin
        ack_ok   = bus.game_ack && to_cnt != '0;
        to_done  = to_cnt == TW'(ACK_TO - 1);
        gap_done = gap_cnt == GW'(GAP_CYC - 1);
        st_n     = st;
        unique case (st)
            S_IDLE:   st_n = run ? S_WAIT : S_IDLE;
            S_WAIT:   st_n = !run ? S_IDLE : !tick ? S_WAIT : div == '0 ? S_UPDATE : S_SNAP;
            S_UPDATE: st_n = (ack_ok || to_done) ? S_SNAP : S_UPDATE;
            S_SNAP:   st_n = S_SEND;
            S_SEND:   st_n = bus.tx_done ? S_GAP : S_SEND;
            S_GAP:    st_n = gap_done ? S_WAIT : S_GAP;
            default:  st_n = S_IDLE;
        endcase
    end

    // state, counters, sticky flags and registered outputs decoded from the next state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            st            <= S_IDLE;
            div           <= '0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            frame_cnt     <= '0;
            overrun       <= 1'b0;
            ack_err       <= 1'b0;
            bus.game_req  <= 1'b0;
            bus.snap_en   <= 1'b0;
            bus.tx_start  <= 1'b0;
            bus.line_hold <= 1'b0;
        end else begin
            st            <= st_n;
            div           <= st == S_IDLE ? '0 :
                             (st == S_WAIT && run && tick) ? (div == 8'(GAME_DIV - 1) ? '0 : div + 8'd1) : div;
            to_cnt        <= st == S_UPDATE ? to_cnt + 1'b1 : '0;
            gap_cnt       <= st == S_GAP ? gap_cnt + 1'b1 : '0;
            frame_cnt     <= frame_cnt + 16'(st == S_GAP && gap_done);
            overrun       <= overrun || (tick && st != S_IDLE && st != S_WAIT);
            ack_err       <= ack_err || (st == S_UPDATE && to_done && !ack_ok);
            bus.game_req  <= st_n == S_UPDATE && st != S_UPDATE;
            bus.snap_en   <= st_n == S_SNAP;
            bus.tx_start  <= st_n == S_SEND && st != S_SEND;
            bus.line_hold <= st_n == S_GAP;
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: scoreboard bench for frame_sched with randomized frame timing
module tb_frame_sched;
    import frame_sched_pkg::*;

    localparam int FRAME_CYC = 100;
    localparam int GAME_DIV  = 2;
    localparam int GAP_CYC   = 5;
    localparam int ACK_TO    = 8;
    localparam int EV_REQ = 0, EV_SNAP = 1, EV_TX = 2, EV_DONE = 3;

    typedef struct { int kind; int cyc; int val; } ev_t;

    logic        sys_clk, sys_rst, run;
    logic [15:0] frame_cnt;
    logic [2:0]  state;
    logic        overrun, ack_err;

    frame_sched_if bus();

    frame_sched #(.FRAME_CYC(FRAME_CYC), .GAME_DIV(GAME_DIV), .GAP_CYC(GAP_CYC), .ACK_TO(ACK_TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .run       (run),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .state     (state),
        .overrun   (overrun),
        .ack_err   (ack_err)
    );

    ev_t         sbq[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          div_m, frame_m, earliest, hold_n;
    bit          err_m, ov_m, mon_en;
    logic [15:0] fc_prev;
    ev_t         ev;

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= sys_rst ? 0 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hit(input int w);
        return w == 0 ? bus.game_req : w == 2 ? bus.tx_start : w == 3 ? bus.line_hold :
               w == 4 ? (bus.game_req || bus.snap_en) : bus.snap_en;
    endfunction

    task automatic wait_for(input int which, output int ok);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!hit(which) && n < 400);
        ok = hit(which);
        chk($sformatf("wait_%0d_seen", which), ok, 1);
    endtask

    task automatic pulse(input int w, input int d);
        repeat (d) @(negedge sys_clk);
        if (w == 0) bus.game_ack = 1; else bus.tx_done = 1;
        @(negedge sys_clk);
        bus.game_ack = 0;
        bus.tx_done  = 0;
    endtask

    task automatic push(input int k, input int c, input int v);
        ev_t x;
        x.kind = k; x.cyc = c; x.val = v;
        sbq.push_back(x);
    endtask

    task automatic restart(input bit r);
        mon_en  = 0;
        sys_rst = 1;
        run     = r;
        @(negedge sys_clk);
        sys_rst = 0;
        sbq.delete();
        div_m = 0; frame_m = 0; err_m = 0; ov_m = 0; earliest = 1;
        @(negedge sys_clk);
        mon_en = 1;
    endtask

    // One frame: frames start on a tick, step the game every GAME_DIV accepted frames,
    // and any tick strictly inside a frame is an overrun.
    task automatic do_frame(input int da, input int dt, input bit stop, input bit stray);
        bit has_req;
        int ok, start, g, s, e, snap_exp;
        has_req = div_m == 0;
        div_m = (div_m + 1) % GAME_DIV;
        if (stray) begin
            pulse(1, 1);
            chk("stray_done_state", int'(state), int'(S_WAIT));
            chk("stray_done_flags", int'({overrun, ack_err}), int'({ov_m, err_m}));
        end
        if (has_req) push(EV_REQ, -1, 0); else push(EV_SNAP, -1, 0);
        wait_for(4, ok);
        start = cyc - 1;
        chk("frame_start", start, ((earliest + FRAME_CYC - 1) / FRAME_CYC) * FRAME_CYC);
        if (has_req) begin
            g = cyc;
            snap_exp = da < ACK_TO ? g + da + 1 : g + ACK_TO;
            push(EV_SNAP, snap_exp, 0);
            push(EV_TX, snap_exp + 1, 0);
            if (da < ACK_TO) pulse(0, da);
        end else push(EV_TX, cyc + 1, 0);
        wait_for(2, ok);
        s = cyc;
        if (stop) run = 0;
        e = s + dt + 1 + GAP_CYC;
        frame_m++;
        push(EV_DONE, e, frame_m & 16'hffff);
        if (stray) begin
            pulse(0, 1);
            chk("stray_ack_state", int'(state), int'(S_SEND));
            chk("stray_ack_err", int'(ack_err), int'(err_m));
            pulse(1, dt - 2);
        end else pulse(1, dt);
        while (cyc < e) @(negedge sys_clk);
        err_m = err_m | (has_req && da >= ACK_TO);
        for (int t = start + 1; t < e; t++) if (t % FRAME_CYC == 0) ov_m = 1;
        chk("ack_err", int'(ack_err), int'(err_m));
        chk("overrun", int'(overrun), int'(ov_m));
        chk("frame_cnt", int'(frame_cnt), frame_m);
        earliest = e;
    endtask

    // monitor: pops the scoreboard on every pulse and frame_cnt change, measures the latch gap
    initial begin
        hold_n = 0;
        fc_prev = '0;
        forever begin
            @(negedge sys_clk);
            if (mon_en && (bus.game_req || bus.snap_en || bus.tx_start)) begin
                chk("pulse_onehot", int'(bus.game_req) + int'(bus.snap_en) + int'(bus.tx_start), 1);
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: got req/snap/tx %0d%0d%0d expected none (cycle %0d)",
                             bus.game_req, bus.snap_en, bus.tx_start, cyc);
                end else begin
                    ev = sbq.pop_front();
                    chk("pulse_kind", bus.game_req ? EV_REQ : bus.snap_en ? EV_SNAP : EV_TX, ev.kind);
                    if (ev.cyc >= 0) chk("pulse_cycle", cyc, ev.cyc);
                end
            end
            if (mon_en && frame_cnt != fc_prev) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame_done: got frame_cnt %0d expected no change (cycle %0d)", frame_cnt, cyc);
                end else begin
                    ev = sbq.pop_front();
                    chk("done_kind", EV_DONE, ev.kind);
                    chk("done_value", int'(frame_cnt), ev.val);
                    chk("done_cycle", cyc, ev.cyc);
                end
            end
            fc_prev = frame_cnt;
            if (!mon_en) hold_n = 0;
            else if (bus.line_hold) hold_n++;
            else if (hold_n != 0) begin
                chk("gap_len", hold_n, GAP_CYC);
                hold_n = 0;
            end
        end
    end

    initial begin
        int ok, n, da, dt;
        sys_rst = 1; run = 0; bus.game_ack = 0; bus.tx_done = 0; mon_en = 0;
        repeat (3) @(negedge sys_clk);
        chk("rst_state", int'(state), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_flags", int'({overrun, ack_err}), 0);
        chk("rst_outputs", int'({bus.game_req, bus.snap_en, bus.tx_start, bus.line_hold}), 0);

        restart(1);
        do_frame(3, 20, 0, 0);
        do_frame(3, 20, 0, 0);

        restart(1);
        do_frame(99, 20, 0, 0);

        restart(1);
        do_frame(3, 150, 0, 0);
        do_frame(3, 20, 0, 0);

        restart(1);
        do_frame(3, 20, 0, 1);

        restart(1);
        for (int i = 0; i < 25; i++) begin
            da = $urandom_range(1, 10);
            dt = $urandom_range(0, 5) == 0 ? $urandom_range(100, 160) : $urandom_range(3, 60);
            do_frame(da, dt, 0, 0);
        end

        restart(1);
        do_frame(3, 20, 1, 0);
        repeat (2) @(negedge sys_clk);
        chk("stop_state", int'(state), int'(S_IDLE));
        n = 0;
        repeat (250) begin
            @(negedge sys_clk);
            if (bus.tx_start) n++;
        end
        chk("stop_no_tx", n, 0);
        chk("stop_frame_cnt", int'(frame_cnt), 1);

        restart(1);
        mon_en = 0;
        wait_for(0, ok);
        pulse(0, 2);
        wait_for(2, ok);
        pulse(1, 2);
        wait_for(3, ok);
        sys_rst = 1;
        @(negedge sys_clk);
        sys_rst = 0;
        chk("gap_rst_line_hold", int'(bus.line_hold), 0);
        chk("gap_rst_frame_cnt", int'(frame_cnt), 0);
        chk("gap_rst_state", int'(state), 0);
        n = 0;
        repeat (95) begin
            @(negedge sys_clk);
            if (bus.game_req || bus.snap_en || bus.tx_start) n++;
        end
        chk("gap_rst_no_pulse", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter FRAME_CYC, default 1_666_666, meaning sys_clk cycles per frame tick (30 Hz at 50 MHz); legal range 64 and above.
REQ-002 Parameter GAME_DIV, default 8, meaning frames per game step (1..255).
REQ-003 Parameter GAP_CYC, default 15_000, meaning WS2812 latch gap in cycles (300 us); legal range 1 and above.
REQ-004 Parameter ACK_TO, default 4096, meaning maximum cycles to wait for game_ack; legal range 1 and above.
REQ-005 sys_clk  in  1  sole clock, rising edge.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 run  in  1  scheduler enable.
REQ-008 game_req  out  1  one-cycle pulse permitting one snake-engine step.
REQ-009 game_ack  in  1  one-cycle pulse: snake step complete.
REQ-010 snap_en  out  1  one-cycle pulse: copy snake_body into the frame buffer.
REQ-011 tx_start  out  1  one-cycle pulse: start the WS2812 serializer.
REQ-012 tx_done  in  1  one-cycle pulse: last pixel bit shifted out.
REQ-013 line_hold  out  1  high while the WS2812 data line must be held low (latch gap).
REQ-014 frame_cnt  out  16  completed-frame count, wraps at 65535 to 0.
REQ-015 state  out  3  current FSM state code, for debug.
REQ-016 overrun  out  1  sticky: a frame tick arrived while a frame was in progress.
REQ-017 ack_err  out  1  sticky: the game_ack timeout expired.

Function
REQ-018 Free-running tick counter 0..FRAME_CYC-1; tick asserted for one cycle at wrap; the counter runs independently of run.
REQ-019 States and codes: IDLE=0, WAIT=1, UPDATE=2, SNAP=3, SEND=4, GAP=5.
REQ-020 IDLE to WAIT when run=1; every other state returns to IDLE only from WAIT when run=0, so a frame in progress always completes.
REQ-021 WAIT to UPDATE on tick when the game divider=0; WAIT to SNAP on tick otherwise.
REQ-022 The game divider counts 0..GAME_DIV-1 and advances on every accepted tick; it is cleared on IDLE entry.
REQ-023 game_req pulses in the first UPDATE cycle; game_ack is sampled from the following cycle onward.
REQ-024 UPDATE to SNAP on game_ack, or after ACK_TO cycles without it; on timeout, ack_err is set.
REQ-025 snap_en pulses for the single SNAP cycle; SNAP to SEND unconditionally.
REQ-026 tx_start pulses in the first SEND cycle; SEND to GAP on tx_done.
REQ-027 line_hold=1 for exactly GAP_CYC cycles in GAP; GAP to WAIT afterwards, and frame_cnt increments by 1 on that transition.
REQ-028 A tick occurring in any state other than WAIT or IDLE sets overrun and is dropped; the divider does not advance.
REQ-029 A tick in the same cycle as the GAP to WAIT transition is treated as an overrun.
REQ-030 game_ack outside UPDATE, and tx_done outside SEND, are ignored.
REQ-031 All outputs are registered; the pulse outputs are never asserted together.

Reset
REQ-032 On sys_rst=1: state=IDLE; tick counter, divider, gap counter and timeout counter=0; all pulse outputs=0; line_hold=0; frame_cnt=0; overrun=0; ack_err=0.
REQ-033 Reset mid-frame aborts immediately with no further pulses; the first tx_start after reset requires a new tick.

Structure
REQ-034 The state encodings and the default FRAME_CYC/GAP_CYC constants reside in a shared snake package, reused by the snake engine and the ws2812 control path.
REQ-035 One sub-module, frame_tick_gen (parameterised tick divider), supplies tick; the FSM stays in frame_sched.

Verification
REQ-036 Run the bench with FRAME_CYC=100, GAME_DIV=2, GAP_CYC=5, ACK_TO=8.
REQ-037 Nominal: run=1, game_ack 3 cycles after game_req, tx_done 20 cycles after tx_start -> sequence game_req, snap_en, tx_start, line_hold for 5 cycles; frame_cnt=1 after the frame; the next frame skips game_req.
REQ-038 Ack timeout: game_ack never driven -> SNAP entered 8 cycles after game_req; ack_err=1; frame completes with frame_cnt=1.
REQ-039 Overrun: tx_done delayed 150 cycles -> overrun=1; the dropped tick produces no game_req or snap_en; the following frame proceeds normally.
REQ-040 Stop mid-frame: run deasserted during SEND -> tx_done, gap and frame_cnt increment still complete, then state=0 and no further tx_start.
REQ-041 Reset during GAP: sys_rst for 1 cycle -> line_hold=0, frame_cnt=0, state=0 the next cycle.
REQ-042 Stray inputs: tx_done pulsed in WAIT and game_ack in SEND -> no state change and no flags set.
